instr_fetch_unit: RTL

Instruction-fetch initiator for the pipelined CPU: owns the program counter, drives the word address into the combinational instruction memory, captures the returned instruction word, and buffers it with its PC in a small FIFO presented to the decode stage through a valid/ready handshake. Handles stall back-pressure from decode, branch/jump redirect with queue flush, and sticky fetch-fault detection. Sits between the instruction memory and the IF/ID boundary.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory address/data, redirect, decode handshake and fault.
// master = fetch unit side, slave = memory/decode/branch-resolution side.
interface instr_fetch_unit_if;
    logic [31:0] pc_addr_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        fault_o;

    modport master (
        output pc_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, fault_o,
        input  instr_i, redirect_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  pc_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o, fault_o,
        output instr_i, redirect_i, redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC + small {pc,instr} queue to decode; 1-cycle fetch-to-decode latency (0 with FETCH_BYPASS_EN).
// Back-pressure: id_ready_i low fills the queue then freezes the PC; redirect flushes; fault freezes fetch until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 32,
    parameter int          QDEPTH    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    instr_fetch_unit_if.master    bus
);

    localparam int          PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CW       = $clog2(QDEPTH + 1);
    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

    logic [31:0]   pc;
    logic          fault;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic          pc_legal;
    logic          fifo_pop;
    logic          has_space;
    logic          fetch_ok;
    logic          take_redirect;
    logic          bypass_sel;
    logic          push;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_instr;

    always_comb begin
        pc_legal      = (pc < PC_LIMIT) && (pc[1:0] == 2'b00);
        // Only a pop from the queue frees a slot; a bypassed word never occupies one.
        fifo_pop      = (count != '0) && bus.id_ready_i;
        has_space     = (count < CW'(QDEPTH)) || fifo_pop;
        fetch_ok      = !fault && !bus.redirect_i && has_space && pc_legal;
        take_redirect = bus.redirect_i && !fault;
`ifdef FETCH_BYPASS_EN
        bypass_sel    = (count == '0) && fetch_ok;
        push          = fetch_ok && !(bypass_sel && bus.id_ready_i);
`else
        bypass_sel    = 1'b0;
        push          = fetch_ok;
`endif
        id_valid      = (count != '0) || bypass_sel;
        id_pc         = bypass_sel ? pc           : q_pc[head];
        id_instr      = bypass_sel ? bus.instr_i  : q_instr[head];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (take_redirect) begin
            pc    <= bus.redirect_pc_i;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (!fault && !pc_legal) begin
                fault <= 1'b1;
            end
            if (push) begin
                q_pc[tail]    <= pc;
                q_instr[tail] <= bus.instr_i;
                tail          <= tail + PW'(1);
            end
            if (fifo_pop) begin
                head <= head + PW'(1);
            end
            if (fetch_ok) begin
                pc <= pc + 32'd4;
            end
            case ({push, fifo_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.pc_addr_o     = pc;
    assign bus.id_valid_o    = id_valid;
    assign bus.id_pc_o       = id_pc;
    assign bus.id_instr_o    = id_instr;
    assign bus.id_pc_plus4_o = id_pc + 32'd4;
    assign bus.fault_o       = fault;

endmodule
